// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider with shadowed period/high-time settings applied at period boundaries.
// Optional CLOCK_DIVIDER_PERIOD_CNT_EN adds a 16-bit completed-period counter output.
module clock_divider_prog #(
  parameter int WIDTH    = 28,
  parameter int DEF_DIV  = 200000,
  parameter int DEF_HIGH = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             clock_out,
  output logic             tick,
  output logic             cfg_pending
`ifdef CLOCK_DIVIDER_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  localparam int DIV_S_I  = (DEF_DIV < 2) ? 2 : DEF_DIV;
  localparam int HIGH_S_I = (DEF_HIGH < 1) ? 1 :
                            ((DEF_HIGH > DIV_S_I - 1) ? DIV_S_I - 1 : DEF_HIGH);
  localparam logic [WIDTH-1:0] DEF_DIV_S  = WIDTH'(DIV_S_I);
  localparam logic [WIDTH-1:0] DEF_HIGH_S = WIDTH'(HIGH_S_I);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_act;
  logic [WIDTH-1:0] r_high_act;
  logic [WIDTH-1:0] r_div_sh;
  logic [WIDTH-1:0] r_high_sh;
  logic             r_pending;
  logic             r_clock_out;
  logic             r_tick;

  logic [WIDTH-1:0] w_div_sat;
  logic [WIDTH-1:0] w_high_sat;
  logic             w_last;
  logic             w_apply;

  // Sanitize the shadow so the active pair always yields a toggling output.
  always_comb begin
    w_div_sat  = (r_div_sh < WIDTH'(2)) ? WIDTH'(2) : r_div_sh;
    w_high_sat = r_high_sh;
    if (r_high_sh == '0)
      w_high_sat = WIDTH'(1);
    else if (r_high_sh > w_div_sat - WIDTH'(1))
      w_high_sat = w_div_sat - WIDTH'(1);
  end

  assign w_last  = (r_cnt == r_div_act - WIDTH'(1));
  // Idle applies pending settings at once; running waits for the wrap.
  assign w_apply = r_pending && (!en || w_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_div_act   <= DEF_DIV_S;
      r_high_act  <= DEF_HIGH_S;
      r_div_sh    <= WIDTH'(DEF_DIV);
      r_high_sh   <= WIDTH'(DEF_HIGH);
      r_pending   <= 1'b0;
      r_clock_out <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      if (en) begin
        r_clock_out <= (r_cnt < r_high_act);
        r_tick      <= w_last;
        r_cnt       <= w_last ? '0 : r_cnt + WIDTH'(1);
      end else begin
        r_cnt       <= '0;
        r_clock_out <= 1'b0;
        r_tick      <= 1'b0;
      end

      if (w_apply) begin
        r_div_act  <= w_div_sat;
        r_high_act <= w_high_sat;
      end

      if (load) begin
        r_div_sh  <= div_in;
        r_high_sh <= high_in;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign clock_out   = r_clock_out;
  assign tick        = r_tick;
  assign cfg_pending = r_pending;

`ifdef CLOCK_DIVIDER_PERIOD_CNT_EN
  logic [15:0] r_period_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_period_cnt <= '0;
    else if (en && w_last)
      r_period_cnt <= r_period_cnt + 16'd1;
  end

  assign period_cnt = r_period_cnt;
`endif

endmodule
